vram_arbiter: RTL and testbench
===============================

Name: vram_arbiter

Overview:
- Downstream slave of the 6502 bus-interface bus-master port.
- Decodes each bus-master access (19-bit address, strobe, write) to one of three targets: the single-port VRAM, the palette RAM, or the unmapped space.
- Shares the VRAM with the video fetch engine. The bus master has absolute priority and a fixed one-cycle read latency; video fetches are stalled with a req/ack handshake.

Parameters:
VRAM_AW, 17, VRAM byte-address width; VRAM region is 0 .. 2^VRAM_AW-1.
PAL_BASE, 19'h40000, base of palette region; must be aligned to 2^PAL_AW.
PAL_AW, 9, palette byte-address width; region is PAL_BASE .. PAL_BASE+2^PAL_AW-1.

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
bm_addr  in  19  bus-master address
bm_wrdata  in  8  bus-master write data
bm_strobe  in  1  single-cycle access request
bm_write  in  1  1=write, 0=read; qualified by bm_strobe
bm_rddata  out  8  bus-master read data
vid_req  in  1  video fetch request; held until acked
vid_addr  in  VRAM_AW  video fetch address; held with vid_req
vid_ack  out  1  pulse: video fetch issued this cycle
vid_rddata  out  8  video read data
vid_valid  out  1  pulse: vid_rddata valid
vram_addr  out  VRAM_AW  VRAM address
vram_wrdata  out  8  VRAM write data
vram_we  out  1  VRAM write enable
vram_en  out  1  VRAM access enable
vram_rddata  in  8  VRAM read data, valid the cycle after an enabled read
pal_addr  out  PAL_AW  palette address
pal_wrdata  out  8  palette write data
pal_we  out  1  palette write enable
pal_en  out  1  palette access enable
pal_rddata  in  8  palette read data, valid the cycle after an enabled read

Behaviour:
- Target decode on bm_addr, evaluated only in a bm_strobe cycle:
  - VRAM: bm_addr < 2^VRAM_AW.
  - Palette: bm_addr[18:PAL_AW] == PAL_BASE[18:PAL_AW].
  - Anything else is unmapped.
- The RAM-side outputs (vram_*, pal_*) are combinational from the current-cycle requests. The cycle in which a RAM is enabled is the "issue" cycle.
- Issue priority for VRAM in any cycle:
  1. A bm_strobe decoding to VRAM drives vram_en=1, vram_we=bm_write, vram_addr=bm_addr[VRAM_AW-1:0], vram_wrdata=bm_wrdata. vid_ack=0, and the video request stays pending.
  2. Otherwise, if vid_req=1: vram_en=1, vram_we=0, vram_addr=vid_addr, vid_ack=1.
  3. Otherwise vram_en=0.
- A bus-master palette or unmapped access does not block video: vid_ack may be asserted in the same cycle.
- Palette: pal_en=1 only for a bm_strobe decoding to palette; pal_we=bm_write.
- Unmapped writes are dropped. Unmapped reads return 8'h00.
- Return tag: a register loaded every cycle with one of NONE / BM_VRAM / BM_PAL / BM_UNM for the bus-master read, plus a separate vid_pend bit = vid_ack. Writes load NONE.
- Bus-master read latency is exactly 1 cycle. In the cycle after a bm read strobe, bm_rddata is combinationally selected: vram_rddata, pal_rddata, or 8'h00 per the tag.
- In the same cycle a bm_hold register captures that value. In all other cycles bm_rddata = bm_hold, so it is stable until the next read.
- Video return: vid_valid=vid_pend, vid_rddata=vram_rddata in the cycle after vid_ack.
- No starvation logic is needed. Bus-master strobes are at least 4 cycles apart, so a video request waits at most 1 cycle. A request back-to-back with a strobe is still handled correctly.
- Same-address ordering: a bm VRAM write and a pending video read to the same address in the same cycle execute write first. The video read is issued the next cycle and returns the new data.
- Reset:
  - bm_rddata=0, vid_valid=0, vid_rddata=0, tag=NONE, vid_pend=0.
  - All enables, write enables and vid_ack are 0 while rst=1, even if strobe or req is asserted.
  - Reset mid-operation discards any in-flight return: no vid_valid and no bm_rddata update in the cycle after rst deasserts.
- Address out-of-range bits: vid_addr is VRAM_AW wide, so no wrap is possible. A bm_addr between 2^VRAM_AW and PAL_BASE is unmapped, with no aliasing.

Test Plan:
1. Bus-master VRAM write then read: write 8'hA5 to 19'h01234, then read it → vram_we pulse with vram_addr=17'h01234; bm_rddata=8'hA5 exactly 1 cycle after the read strobe, held afterwards.
2. Collision: vid_req=1, vid_addr=17'h00010 continuously; bm write 8'h3C to 19'h00010 in cycle T → vid_ack=0 at T, vid_ack=1 at T+1, vid_valid=1 with vid_rddata=8'h3C at T+2.
3. Palette path: bm write 8'h7E to 19'h40005, read back; video active throughout → pal_addr=9'h005, bm_rddata=8'h7E; vid_ack uninterrupted in the palette cycles.
4. Unmapped space: write 8'hFF to 19'h20000, read 19'h20000 and 19'h7FFFF → no vram_en/pal_en; bm_rddata=8'h00.
5. Continuous video stream with no bus-master traffic, addresses 0..15 → vid_ack every cycle; vid_valid every cycle from the second; data matches a memory model.
6. Reset asserted the cycle after a bm read and a vid_ack → all outputs are reset values; no vid_valid; bm_rddata=0 after reset releases.

Source files
------------

// File: rtl/vram_arbiter.sv
// Bus-master / video-fetch arbiter for a single-port VRAM plus palette RAM.
// The bus master always wins VRAM; its reads return exactly one cycle after the strobe.
module vram_arbiter #(
    parameter int          VRAM_AW  = 17,
    parameter logic [18:0] PAL_BASE = 19'h40000,
    parameter int          PAL_AW   = 9
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [18:0]        bm_addr,
    input  logic [7:0]         bm_wrdata,
    input  logic               bm_strobe,
    input  logic               bm_write,
    output logic [7:0]         bm_rddata,
    input  logic               vid_req,
    input  logic [VRAM_AW-1:0] vid_addr,
    output logic               vid_ack,
    output logic [7:0]         vid_rddata,
    output logic               vid_valid,
    output logic [VRAM_AW-1:0] vram_addr,
    output logic [7:0]         vram_wrdata,
    output logic               vram_we,
    output logic               vram_en,
    input  logic [7:0]         vram_rddata,
    output logic [PAL_AW-1:0]  pal_addr,
    output logic [7:0]         pal_wrdata,
    output logic               pal_we,
    output logic               pal_en,
    input  logic [7:0]         pal_rddata
);

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_VRAM = 2'd1,
        TAG_PAL  = 2'd2,
        TAG_UNM  = 2'd3
    } tag_t;

    localparam logic [18-PAL_AW:0] PAL_TAG = PAL_BASE[18:PAL_AW];

    tag_t       r_tag;
    logic       r_vid_pend;
    logic [7:0] r_bm_hold;

    logic       w_bm_vram;
    logic       w_bm_pal;
    logic       w_vid_ack;
    logic [7:0] w_ret_data;
    tag_t       w_next_tag;

    assign w_bm_vram = bm_strobe && (bm_addr[18:VRAM_AW] == '0);
    assign w_bm_pal  = bm_strobe && (bm_addr[18:PAL_AW] == PAL_TAG);
    // A bus-master VRAM access defers video by a cycle, which also gives write-before-read ordering.
    assign w_vid_ack = !rst && vid_req && !w_bm_vram;

    assign vram_en     = !rst && (w_bm_vram || vid_req);
    assign vram_we     = !rst && w_bm_vram && bm_write;
    assign vram_addr   = w_bm_vram ? bm_addr[VRAM_AW-1:0] : vid_addr;
    assign vram_wrdata = bm_wrdata;
    assign vid_ack     = w_vid_ack;

    assign pal_en     = !rst && w_bm_pal;
    assign pal_we     = !rst && w_bm_pal && bm_write;
    assign pal_addr   = bm_addr[PAL_AW-1:0];
    assign pal_wrdata = bm_wrdata;

    always_comb begin
        w_next_tag = TAG_NONE;
        if (bm_strobe && !bm_write) begin
            if (w_bm_vram)     w_next_tag = TAG_VRAM;
            else if (w_bm_pal) w_next_tag = TAG_PAL;
            else               w_next_tag = TAG_UNM;
        end
    end

    always_comb begin
        w_ret_data = 8'h00;
        case (r_tag)
            TAG_VRAM: w_ret_data = vram_rddata;
            TAG_PAL:  w_ret_data = pal_rddata;
            default:  w_ret_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag      <= TAG_NONE;
            r_vid_pend <= 1'b0;
            r_bm_hold  <= 8'h00;
        end else begin
            r_tag      <= w_next_tag;
            r_vid_pend <= w_vid_ack;
            if (r_tag != TAG_NONE) r_bm_hold <= w_ret_data;
        end
    end

    // Returns are gated by rst so an in-flight read never escapes while reset is applied.
    assign bm_rddata  = rst ? 8'h00 : ((r_tag != TAG_NONE) ? w_ret_data : r_bm_hold);
    assign vid_valid  = !rst && r_vid_pend;
    assign vid_rddata = (!rst && r_vid_pend) ? vram_rddata : 8'h00;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with behavioural VRAM/palette RAMs and
// reference memories feeding expected-value queues.
module tb_vram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [18:0] bm_addr;
    logic [7:0]  bm_wrdata;
    logic        bm_strobe;
    logic        bm_write;
    logic [7:0]  bm_rddata;
    logic        vid_req;
    logic [16:0] vid_addr;
    logic        vid_ack;
    logic [7:0]  vid_rddata;
    logic        vid_valid;
    logic [16:0] vram_addr;
    logic [7:0]  vram_wrdata;
    logic        vram_we;
    logic        vram_en;
    logic [7:0]  vram_rddata;
    logic [8:0]  pal_addr;
    logic [7:0]  pal_wrdata;
    logic        pal_we;
    logic        pal_en;
    logic [7:0]  pal_rddata;

    int n_assert = 0;
    int n_fail   = 0;

    bit [7:0] ram_mem [0:131071];
    bit [7:0] pal_mem [0:511];
    bit [7:0] ref_mem [0:131071];
    bit [7:0] ref_pal [0:511];

    logic [7:0] vid_exp_q[$];
    logic [7:0] bm_exp_q[$];
    logic [7:0] last_bm;

    vram_arbiter dut (
        .clk(clk), .rst(rst),
        .bm_addr(bm_addr), .bm_wrdata(bm_wrdata), .bm_strobe(bm_strobe),
        .bm_write(bm_write), .bm_rddata(bm_rddata),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
        .vid_rddata(vid_rddata), .vid_valid(vid_valid),
        .vram_addr(vram_addr), .vram_wrdata(vram_wrdata), .vram_we(vram_we),
        .vram_en(vram_en), .vram_rddata(vram_rddata),
        .pal_addr(pal_addr), .pal_wrdata(pal_wrdata), .pal_we(pal_we),
        .pal_en(pal_en), .pal_rddata(pal_rddata)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM models driven only by the DUT's RAM-side ports.
    always @(posedge clk) begin
        if (vram_en) begin
            if (vram_we) ram_mem[vram_addr] <= vram_wrdata;
            else         vram_rddata <= ram_mem[vram_addr];
        end
        if (pal_en) begin
            if (pal_we) pal_mem[pal_addr] <= pal_wrdata;
            else        pal_rddata <= pal_mem[pal_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Video return scoreboard: an ack pushes reference data, a valid pops it.
    always @(negedge clk) begin
        if (rst) begin
            vid_exp_q.delete();
        end else begin
            if (vid_valid) begin
                if (vid_exp_q.size() == 0) begin
                    check("vid_valid_unexpected", 32'(vid_valid), 32'd0);
                end else begin
                    check("vid_rddata", 32'(vid_rddata), 32'(vid_exp_q.pop_front()));
                end
            end
            if (vid_ack) vid_exp_q.push_back(ref_mem[vid_addr]);
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One bus-master access followed by three idle cycles (strobe spacing of 4).
    task automatic bm_access(input logic [18:0] a, input logic w, input logic [7:0] d);
        logic is_vram;
        logic is_pal;
        logic [7:0] exp_rd;
        is_vram = (a < 19'h20000);
        is_pal  = (a[18:9] == 10'h200);
        next_cycle();
        bm_addr = a; bm_wrdata = d; bm_write = w; bm_strobe = 1'b1;
        if (w && is_vram) ref_mem[a[16:0]] = d;
        if (w && is_pal)  ref_pal[a[8:0]]  = d;
        if (!w) begin
            exp_rd = is_vram ? ref_mem[a[16:0]] : (is_pal ? ref_pal[a[8:0]] : 8'h00);
            bm_exp_q.push_back(exp_rd);
        end
        @(negedge clk);
        check("vram_en", 32'(vram_en), 32'(is_vram | vid_req));
        check("pal_en", 32'(pal_en), 32'(is_pal));
        check("vid_ack_issue", 32'(vid_ack), 32'(vid_req & ~is_vram));
        if (is_vram) begin
            check("vram_addr", 32'(vram_addr), 32'(a[16:0]));
            check("vram_we", 32'(vram_we), 32'(w));
        end
        if (is_pal) begin
            check("pal_addr", 32'(pal_addr), 32'(a[8:0]));
            check("pal_we", 32'(pal_we), 32'(w));
        end
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            bm_strobe = 1'b0; bm_write = 1'b0;
            @(negedge clk);
            check("vid_ack_idle", 32'(vid_ack), 32'(vid_req));
            check("pal_en_idle", 32'(pal_en), 32'd0);
            if (k == 0 && !w) last_bm = bm_exp_q.pop_front();
            check("bm_rddata", 32'(bm_rddata), 32'(last_bm));
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram_mem[i] = 8'($urandom_range(0, 255));
            ref_mem[i] = ram_mem[i];
        end
        last_bm = 8'h00;
        rst = 1'b1;
        bm_addr = 19'h00000; bm_wrdata = 8'h00; bm_write = 1'b1; bm_strobe = 1'b1;
        vid_req = 1'b1; vid_addr = 17'h00000;
        repeat (3) next_cycle();
        @(negedge clk);
        check("rst_vram_en", 32'(vram_en), 32'd0);
        check("rst_vram_we", 32'(vram_we), 32'd0);
        check("rst_vid_ack", 32'(vid_ack), 32'd0);
        check("rst_bm_rddata", 32'(bm_rddata), 32'd0);
        check("rst_vid_valid", 32'(vid_valid), 32'd0);
        next_cycle();
        rst = 1'b0; bm_strobe = 1'b0; bm_write = 1'b0; vid_req = 1'b0;
        @(negedge clk);
        check("post_rst_vid_valid", 32'(vid_valid), 32'd0);

        // VRAM write then read back
        bm_access(19'h01234, 1'b1, 8'hA5);
        bm_access(19'h01234, 1'b0, 8'h00);
        check("t1_readback", 32'(last_bm), 32'hA5);

        // Collision: video waits one cycle and sees the freshly written byte
        next_cycle();
        vid_req = 1'b1; vid_addr = 17'h00010;
        bm_access(19'h00010, 1'b1, 8'h3C);
        check("t2_ref", 32'(ref_mem[17'h10]), 32'h3C);

        // Palette traffic does not stall video
        bm_access(19'h40005, 1'b1, 8'h7E);
        bm_access(19'h40005, 1'b0, 8'h00);
        check("t3_readback", 32'(last_bm), 32'h7E);

        // Unmapped space
        next_cycle();
        vid_req = 1'b0;
        bm_access(19'h20000, 1'b1, 8'hFF);
        bm_access(19'h20000, 1'b0, 8'h00);
        bm_access(19'h7FFFF, 1'b0, 8'h00);
        check("t4_readback", 32'(last_bm), 32'h00);

        // Continuous video stream, bus-master read data must stay held
        bm_access(19'h01234, 1'b0, 8'h00);
        for (int i = 0; i < 16; i++) begin
            next_cycle();
            vid_req = 1'b1; vid_addr = 17'(i);
            @(negedge clk);
            check("t5_vid_ack", 32'(vid_ack), 32'd1);
            if (i > 0) check("t5_vid_valid", 32'(vid_valid), 32'd1);
            check("t5_bm_hold", 32'(bm_rddata), 32'(last_bm));
        end
        next_cycle();
        vid_req = 1'b0;
        repeat (3) next_cycle();

        // Reset right after a palette read and a video ack
        vid_req = 1'b1; vid_addr = 17'h00003;
        bm_addr = 19'h40005; bm_write = 1'b0; bm_strobe = 1'b1;
        @(negedge clk);
        check("t6_ack", 32'(vid_ack), 32'd1);
        next_cycle();
        rst = 1'b1; bm_strobe = 1'b0;
        @(negedge clk);
        check("t6_rst_bm_rddata", 32'(bm_rddata), 32'd0);
        check("t6_rst_vid_valid", 32'(vid_valid), 32'd0);
        check("t6_rst_vid_rddata", 32'(vid_rddata), 32'd0);
        check("t6_rst_vram_en", 32'(vram_en), 32'd0);
        check("t6_rst_vid_ack", 32'(vid_ack), 32'd0);
        next_cycle();
        rst = 1'b0; vid_req = 1'b0;
        @(negedge clk);
        check("t6_post_vid_valid", 32'(vid_valid), 32'd0);
        check("t6_post_bm_rddata", 32'(bm_rddata), 32'd0);
        next_cycle();
        @(negedge clk);
        check("t6_post2_bm_rddata", 32'(bm_rddata), 32'd0);
        check("t6_vid_q_empty", 32'(vid_exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
